// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy engine: FSM state encoding,
// register offsets (address bits [3:2]), CTRL bit positions and a
// byte-lane merge helper used by the register file.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_ERR   = 2;
  localparam int CTRL_ABORT = 3;
  localparam int CTRL_IE    = 4;

  // Replace only the byte lanes enabled in mask.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/dma_copy_if.sv
// Bus bundle for dma_copy: the register slave port (address_in .. ready_out),
// the requester master port (dma_*) and the interrupt line.
// modport slave  : view of the dma_copy block itself
// modport master : view of the surrounding system (decoder, arbiter, memory)
interface dma_copy_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [31:0] dma_address_out;
  logic        dma_read_out;
  logic        dma_write_out;
  logic [31:0] dma_read_value_in;
  logic [3:0]  dma_write_mask_out;
  logic [31:0] dma_write_value_out;
  logic        dma_ready_in;
  logic        dma_fault_in;
  logic        irq_out;

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
           dma_read_value_in, dma_ready_in, dma_fault_in,
    output read_value_out, ready_out, dma_address_out, dma_read_out,
           dma_write_out, dma_write_mask_out, dma_write_value_out, irq_out
  );

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
           dma_read_value_in, dma_ready_in, dma_fault_in,
    input  read_value_out, ready_out, dma_address_out, dma_read_out,
           dma_write_out, dma_write_mask_out, dma_write_value_out, irq_out
  );
endinterface

// File: rtl/dma_regs.sv
// Software-visible register file of dma_copy.
//   reg_sel/sel/read/write_mask/write_value : decoded slave access
//   read_value : register read data, 0 unless sel & read
//   adv/set_done/set_err/clr_busy : event strobes from the transfer FSM
//   start : accepted start (CTRL.busy written 1 while idle, LEN != 0)
//   src/dst : word addresses (byte address bits [31:2]); len : remaining words
//   busy/done/error/ie/abort_pend : control state
module dma_regs
  import dma_pkg::*;
#(
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          reg_sel,
  input  logic                sel,
  input  logic                read,
  input  logic [3:0]          write_mask,
  input  logic [31:0]         write_value,
  output logic [31:0]         read_value,
  input  logic                adv,
  input  logic                set_done,
  input  logic                set_err,
  input  logic                clr_busy,
  output logic                start,
  output logic [29:0]         src,
  output logic [29:0]         dst,
  output logic [LEN_BITS-1:0] len,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                ie,
  output logic                abort_pend
);

  logic        wr_en, ctrl_wr, zero_start;
  logic [31:0] cur, merged;

  assign wr_en   = sel && (write_mask != 4'b0000);
  // Every CTRL bit lives in byte lane 0.
  assign ctrl_wr = wr_en && (reg_sel == REG_CTRL) && write_mask[0];

  assign start      = ctrl_wr && write_value[CTRL_BUSY] && !busy && (len != '0);
  assign zero_start = ctrl_wr && write_value[CTRL_BUSY] && !busy && (len == '0);

  always_comb begin
    cur = '0;
    case (reg_sel)
      REG_SRC:  cur = {src, 2'b00};
      REG_DST:  cur = {dst, 2'b00};
      REG_LEN:  cur = 32'(len);
      REG_CTRL: cur = {27'd0, ie, 1'b0, error, done, busy};
      default:  cur = '0;
    endcase
  end

  assign merged     = merge_bytes(cur, write_value, write_mask);
  assign read_value = (sel && read) ? cur : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      ie         <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      // Pointer/count updates from the engine beat software writes; software
      // writes are locked out while busy anyway.
      if (adv) begin
        src <= src + 30'd1;
        dst <= dst + 30'd1;
        len <= len - LEN_BITS'(1);
      end else if (wr_en && !busy) begin
        case (reg_sel)
          REG_SRC: src <= merged[31:2];
          REG_DST: dst <= merged[31:2];
          REG_LEN: len <= merged[LEN_BITS-1:0];
          default: ;
        endcase
      end

      if (start)         busy <= 1'b1;
      else if (clr_busy) busy <= 1'b0;

      // Hardware set beats software write-1-to-clear in the same cycle.
      if (set_done || zero_start)           done <= 1'b1;
      else if (start)                       done <= 1'b0;
      else if (ctrl_wr && write_value[CTRL_DONE]) done <= 1'b0;

      if (set_err)                          error <= 1'b1;
      else if (start)                       error <= 1'b0;
      else if (ctrl_wr && write_value[CTRL_ERR])  error <= 1'b0;

      if (ctrl_wr) ie <= write_value[CTRL_IE];

      // Abort only means something during a transfer; drop it on any stop.
      if (clr_busy || !busy)                          abort_pend <= 1'b0;
      else if (ctrl_wr && write_value[CTRL_ABORT])    abort_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_copy.sv
// Memory-to-memory word copy engine.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : dma_copy_if.slave -- register slave port (SRC/DST/LEN/CTRL
//                at offsets 0x0/0x4/0x8/0xC), requester master port and irq.
// Copies LEN words from SRC to DST as alternating read/write bus requests,
// stopping on completion, a bus fault or a software abort.
module dma_copy
  import dma_pkg::*;
#(
  parameter int LEN_BITS = 16
) (
  input  logic     clk,
  input  logic     reset,
  dma_copy_if.slave bus
);

  state_t              state;
  logic                start, adv, set_done, set_err, clr_busy;
  logic [29:0]         src, dst;
  logic [LEN_BITS-1:0] len;
  logic                busy, done, error, ie, abort_pend;
  logic                last, active, unused_addr;

  // The external decoder already qualified the page; only [3:2] matter here.
  assign unused_addr = ^{bus.address_in[31:4], bus.address_in[1:0], busy, error};

  dma_regs #(.LEN_BITS(LEN_BITS)) u_regs (
    .clk         (clk),
    .reset       (reset),
    .reg_sel     (bus.address_in[3:2]),
    .sel         (bus.sel_in),
    .read        (bus.read_in),
    .write_mask  (bus.write_mask_in),
    .write_value (bus.write_value_in),
    .read_value  (bus.read_value_out),
    .adv         (adv),
    .set_done    (set_done),
    .set_err     (set_err),
    .clr_busy    (clr_busy),
    .start       (start),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .ie          (ie),
    .abort_pend  (abort_pend)
  );

  assign bus.ready_out = bus.sel_in;
  assign bus.irq_out   = done && ie;

  assign last     = (len == LEN_BITS'(1));
  assign active   = (state == ST_RD) || (state == ST_WR);
  assign adv      = (state == ST_WR) && bus.dma_ready_in && !bus.dma_fault_in;
  assign set_done = adv && last;
  assign set_err  = active && bus.dma_ready_in && bus.dma_fault_in;
  assign clr_busy = set_err || set_done || (adv && abort_pend);

  // dma_write_value_out doubles as the data register between RD and WR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= ST_IDLE;
      bus.dma_read_out        <= 1'b0;
      bus.dma_write_out       <= 1'b0;
      bus.dma_write_mask_out  <= 4'b0000;
      bus.dma_address_out     <= '0;
      bus.dma_write_value_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state               <= ST_RD;
            bus.dma_read_out    <= 1'b1;
            bus.dma_address_out <= {src, 2'b00};
          end
        end
        ST_RD: begin
          if (bus.dma_ready_in) begin
            bus.dma_read_out <= 1'b0;
            if (bus.dma_fault_in) begin
              state <= ST_IDLE;
            end else begin
              state                   <= ST_WR;
              bus.dma_write_value_out <= bus.dma_read_value_in;
              bus.dma_write_out       <= 1'b1;
              bus.dma_write_mask_out  <= 4'b1111;
              bus.dma_address_out     <= {dst, 2'b00};
            end
          end
        end
        ST_WR: begin
          if (bus.dma_ready_in) begin
            bus.dma_write_out      <= 1'b0;
            bus.dma_write_mask_out <= 4'b0000;
            // Completion has priority over abort; both end in IDLE.
            if (bus.dma_fault_in || last || abort_pend) begin
              state <= ST_IDLE;
            end else begin
              state               <= ST_RD;
              bus.dma_read_out    <= 1'b1;
              bus.dma_address_out <= {src + 30'd1, 2'b00};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
module tb_dma_copy;
  import dma_pkg::*;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dma_copy_if bus();

  dma_copy #(.LEN_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // Memory model controls (written by stimulus only).
  int          base_lat   = 1;
  bit          stall      = 1'b0;
  bit          fault_en   = 1'b0;
  logic [31:0] fault_addr = '0;

  // Memory model state (written by the responder only).
  int          cnt = 0;
  int          lat = 0;
  int          req_cycles = 0;
  xfer_t       log_q[$];
  logic [31:0] cap_addr, cap_val;
  logic [3:0]  cap_mask;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Source memory content is ~address; writes are recorded in log_q.
  always @(negedge clk) begin
    bus.dma_ready_in = 1'b0;
    bus.dma_fault_in = 1'b0;
    if (reset || !(bus.dma_read_out || bus.dma_write_out)) begin
      cnt = 0;
    end else begin
      req_cycles++;
      if (cnt == 0) begin
        cap_addr = bus.dma_address_out;
        cap_val  = bus.dma_write_value_out;
        cap_mask = bus.dma_write_mask_out;
        lat = stall ? int'($urandom_range(1, 5)) : base_lat;
        chk("req_mask", 65'(bus.dma_write_mask_out), 65'(bus.dma_write_out ? 4'hF : 4'h0));
      end else begin
        chk("hold_addr", 65'(bus.dma_address_out), 65'(cap_addr));
        chk("hold_mask", 65'(bus.dma_write_mask_out), 65'(cap_mask));
        if (bus.dma_write_out)
          chk("hold_val", 65'(bus.dma_write_value_out), 65'(cap_val));
      end
      if (cnt == lat) begin
        bus.dma_ready_in = 1'b1;
        bus.dma_fault_in = fault_en && (bus.dma_address_out == fault_addr);
        if (bus.dma_read_out) begin
          bus.dma_read_value_in = ~bus.dma_address_out;
          log_q.push_back('{1'b0, bus.dma_address_out, ~bus.dma_address_out});
        end else begin
          log_q.push_back('{1'b1, bus.dma_address_out, bus.dma_write_value_out});
        end
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic wr_reg(input logic [1:0] r, input logic [31:0] v);
    @(negedge clk);
    bus.address_in     = {28'h0004000, r, 2'b00};
    bus.sel_in         = 1'b1;
    bus.write_mask_in  = 4'hF;
    bus.write_value_in = v;
    @(posedge clk);
    #1;
    bus.sel_in        = 1'b0;
    bus.write_mask_in = 4'h0;
  endtask

  task automatic rd_reg(input logic [1:0] r, output logic [31:0] v);
    @(negedge clk);
    bus.address_in = {28'h0004000, r, 2'b00};
    bus.sel_in     = 1'b1;
    bus.read_in    = 1'b1;
    #1;
    v = bus.read_value_out;
    bus.sel_in  = 1'b0;
    bus.read_in = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] v;
    rd_reg(r, v);
    chk(tag, 65'(v), 65'(exp));
  endtask

  task automatic wait_idle(input int max);
    logic [31:0] v;
    v = 32'h1;
    for (int i = 0; i < max && v[CTRL_BUSY]; i++) rd_reg(REG_CTRL, v);
    chk("busy_clears", 65'(v[CTRL_BUSY]), 65'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r0;
    logic [31:0] v;
    bus.address_in     = '0;
    bus.sel_in         = 1'b0;
    bus.read_in        = 1'b0;
    bus.write_mask_in  = '0;
    bus.write_value_in = '0;

    // Reset state
    #1;
    chk("rst_outs", 65'({bus.dma_read_out, bus.dma_write_out, bus.dma_write_mask_out, bus.irq_out}), 65'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reg("rst_src",  REG_SRC,  32'h0);
    chk_reg("rst_ctrl", REG_CTRL, 32'h0);
    chk("ready_eq_sel", 65'(bus.ready_out), 65'(0));

    // 1: plain 4-word copy, ie set
    wr_reg(REG_SRC, 32'h1000_0000);
    wr_reg(REG_DST, 32'h1000_0100);
    wr_reg(REG_LEN, 32'h4);
    chk_reg("len_prog", REG_LEN, 32'h4);
    n0 = log_q.size();
    wr_reg(REG_CTRL, 32'h11);
    wait_idle(200);
    chk("t1_count", 65'(log_q.size() - n0), 65'(8));
    if (log_q.size() - n0 == 8) begin
      chk("t1_x0", log_q[n0+0], {1'b0, 32'h1000_0000, 32'hEFFF_FFFF});
      chk("t1_x1", log_q[n0+1], {1'b1, 32'h1000_0100, 32'hEFFF_FFFF});
      chk("t1_x2", log_q[n0+2], {1'b0, 32'h1000_0004, 32'hEFFF_FFFB});
      chk("t1_x3", log_q[n0+3], {1'b1, 32'h1000_0104, 32'hEFFF_FFFB});
      chk("t1_x4", log_q[n0+4], {1'b0, 32'h1000_0008, 32'hEFFF_FFF7});
      chk("t1_x5", log_q[n0+5], {1'b1, 32'h1000_0108, 32'hEFFF_FFF7});
      chk("t1_x6", log_q[n0+6], {1'b0, 32'h1000_000C, 32'hEFFF_FFF3});
      chk("t1_x7", log_q[n0+7], {1'b1, 32'h1000_010C, 32'hEFFF_FFF3});
    end
    chk_reg("t1_len",  REG_LEN,  32'h0);
    chk_reg("t1_src",  REG_SRC,  32'h1000_0010);
    chk_reg("t1_dst",  REG_DST,  32'h1000_0110);
    chk_reg("t1_ctrl", REG_CTRL, 32'h12);
    chk("t1_irq", 65'(bus.irq_out), 65'(1));

    // 2: W1C, then start with LEN=0
    wr_reg(REG_CTRL, 32'h06);
    chk_reg("t2_w1c", REG_CTRL, 32'h0);
    r0 = req_cycles;
    wr_reg(REG_CTRL, 32'h01);
    chk_reg("t2_ctrl", REG_CTRL, 32'h2);
    repeat (5) @(negedge clk);
    chk("t2_no_req", 65'(req_cycles - r0), 65'(0));
    chk("t2_irq_off", 65'(bus.irq_out), 65'(0));

    // 3: fault on read of third word
    wr_reg(REG_SRC, 32'h1000_0000);
    wr_reg(REG_DST, 32'h1000_0200);
    wr_reg(REG_LEN, 32'h4);
    fault_en   = 1'b1;
    fault_addr = 32'h1000_0008;
    n0 = log_q.size();
    wr_reg(REG_CTRL, 32'h01);
    wait_idle(200);
    fault_en = 1'b0;
    chk_reg("t3_ctrl", REG_CTRL, 32'h4);
    chk_reg("t3_src",  REG_SRC,  32'h1000_0008);
    chk_reg("t3_dst",  REG_DST,  32'h1000_0208);
    chk_reg("t3_len",  REG_LEN,  32'h2);
    chk("t3_count", 65'(log_q.size() - n0), 65'(5));
    if (log_q.size() - n0 == 5) begin
      chk("t3_lastw", log_q[n0+3], {1'b1, 32'h1000_0204, 32'hEFFF_FFFB});
      chk("t3_fault", log_q[n0+4], {1'b0, 32'h1000_0008, 32'hEFFF_FFF7});
    end

    // 4: random stalls of 1..5 cycles; hold checks run in the responder
    stall = 1'b1;
    wr_reg(REG_SRC, 32'h1000_0000);
    wr_reg(REG_DST, 32'h1000_0300);
    wr_reg(REG_LEN, 32'h6);
    n0 = log_q.size();
    wr_reg(REG_CTRL, 32'h01);
    wait_idle(500);
    stall = 1'b0;
    chk_reg("t4_ctrl", REG_CTRL, 32'h2);
    chk("t4_count", 65'(log_q.size() - n0), 65'(12));
    if (log_q.size() - n0 == 12)
      for (int i = 0; i < 6; i++)
        chk("t4_wr", log_q[n0+2*i+1], {1'b1, 32'h1000_0300 + 32'(4*i), ~(32'h1000_0000 + 32'(4*i))});

    // 5: abort while word 2 is in flight
    base_lat = 3;
    wr_reg(REG_SRC, 32'h1000_0000);
    wr_reg(REG_DST, 32'h1000_0400);
    wr_reg(REG_LEN, 32'h8);
    n0 = log_q.size();
    wr_reg(REG_CTRL, 32'h01);
    for (int i = 0; i < 100 && (log_q.size() - n0) < 2; i++) @(negedge clk);
    chk("t5_word1", 65'(log_q.size() - n0), 65'(2));
    wr_reg(REG_CTRL, 32'h08);
    wait_idle(200);
    chk_reg("t5_len",  REG_LEN,  32'h6);
    chk_reg("t5_ctrl", REG_CTRL, 32'h0);
    chk_reg("t5_src",  REG_SRC,  32'h1000_0008);
    chk("t5_count", 65'(log_q.size() - n0), 65'(4));

    // 6: async reset during a write request
    wr_reg(REG_LEN, 32'h4);
    wr_reg(REG_CTRL, 32'h11);
    for (int i = 0; i < 100 && !bus.dma_write_out; i++) @(negedge clk);
    chk("t6_wr_seen", 65'(bus.dma_write_out), 65'(1));
    #2 reset = 1'b1;
    #1;
    chk("t6_outs", 65'({bus.dma_read_out, bus.dma_write_out, bus.dma_write_mask_out, bus.irq_out}), 65'(0));
    @(negedge clk);
    reset = 1'b0;
    chk_reg("t6_src",  REG_SRC,  32'h0);
    chk_reg("t6_dst",  REG_DST,  32'h0);
    chk_reg("t6_len",  REG_LEN,  32'h0);
    chk_reg("t6_ctrl", REG_CTRL, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
